gshare_resolve_predictor: RTL and testbench

- Full gshare branch predictor with a resolve/update port. The IF stage queries it with IF_pc and receives predicted_pc in the same cycle.
- The EX stage writes back resolved outcomes: the PHT counters, BTB entries and global history are trained only through this port.
- It is the training end of the prediction interface, replacing the lookup-only predictor. It also keeps branch and mispredict statistics for lab reports.

---
 rtl/gshare_resolve_predictor_if.sv | 33 +++
 rtl/gshare_resolve_predictor.sv | 115 +++++++++++
 tb/tb_gshare_resolve_predictor.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_resolve_predictor_if.sv
// Fetch-side lookup and EX-side resolve/update bundle for the gshare predictor.
// The CPU side drives the master modport and the predictor uses the slave modport.
interface gshare_resolve_predictor_if #(
  parameter int GHR_BITS = 5
);
  logic [31:0]         IF_pc;
  logic [31:0]         predicted_pc;
  logic                pred_taken;
  logic [GHR_BITS-1:0] pred_ghr;

  logic                update_valid;
  logic [31:0]         update_pc;
  logic                update_is_cond;
  logic                update_taken;
  logic [31:0]         update_target;
  logic [GHR_BITS-1:0] update_ghr;
  logic                update_mispredict;

  logic [31:0]         num_branches;
  logic [31:0]         num_mispredicts;

  modport master (
    output IF_pc, update_valid, update_pc, update_is_cond, update_taken,
           update_target, update_ghr, update_mispredict,
    input  predicted_pc, pred_taken, pred_ghr, num_branches, num_mispredicts
  );

  modport slave (
    input  IF_pc, update_valid, update_pc, update_is_cond, update_taken,
           update_target, update_ghr, update_mispredict,
    output predicted_pc, pred_taken, pred_ghr, num_branches, num_mispredicts
  );
endinterface

// File: rtl/gshare_resolve_predictor.sv
// Gshare predictor with BTB: zero-latency lookup for fetch, training only
// through resolved outcomes from EX, plus branch/mispredict statistics.
module gshare_resolve_predictor #(
  parameter int GHR_BITS     = 5,
  parameter int BTB_IDX_BITS = 5
) (
  input logic                        clk,
  input logic                        reset,
  gshare_resolve_predictor_if.slave  bus
);
  localparam int PHT_SIZE = 1 << GHR_BITS;
  localparam int BTB_SIZE = 1 << BTB_IDX_BITS;
  localparam int TAG_BITS = 32 - BTB_IDX_BITS - 2;

  logic [1:0]          pht_reg  [PHT_SIZE];
  logic [1:0]          pht_next [PHT_SIZE];
  logic [GHR_BITS-1:0] ghr_reg;

  logic [BTB_SIZE-1:0] btb_valid_reg;
  logic [BTB_SIZE-1:0] btb_uncond_reg;
  logic [TAG_BITS-1:0] btb_tag_reg    [BTB_SIZE];
  logic [31:0]         btb_target_reg [BTB_SIZE];

  logic [31:0]         num_branches_reg;
  logic [31:0]         num_mispredicts_reg;

  // Lookup path: purely combinational from the registered state, no bypass.
  logic [BTB_IDX_BITS-1:0] lookup_btb_idx;
  logic [GHR_BITS-1:0]     lookup_pht_idx;
  logic                    lookup_hit;
  logic                    lookup_taken;

  assign lookup_btb_idx = bus.IF_pc[BTB_IDX_BITS+1:2];
  assign lookup_pht_idx = bus.IF_pc[GHR_BITS+1:2] ^ ghr_reg;
  assign lookup_hit     = btb_valid_reg[lookup_btb_idx]
                          && (btb_tag_reg[lookup_btb_idx] == bus.IF_pc[31:BTB_IDX_BITS+2]);
  assign lookup_taken   = lookup_hit
                          && (btb_uncond_reg[lookup_btb_idx] || pht_reg[lookup_pht_idx][1]);

  assign bus.pred_taken      = lookup_taken;
  assign bus.predicted_pc    = lookup_taken ? btb_target_reg[lookup_btb_idx]
                                            : bus.IF_pc + 32'd4;
  assign bus.pred_ghr        = ghr_reg;
  assign bus.num_branches    = num_branches_reg;
  assign bus.num_mispredicts = num_mispredicts_reg;

  // Training path: PHT index uses the history captured at fetch time.
  logic                    cond_update;
  logic                    btb_write;
  logic [GHR_BITS-1:0]     train_idx;
  logic [1:0]              train_old;
  logic [1:0]              train_new;
  logic [BTB_IDX_BITS-1:0] update_btb_idx;
  logic                    unused_pc_bits;

  assign cond_update    = bus.update_valid && bus.update_is_cond;
  assign btb_write      = bus.update_valid && (bus.update_taken || !bus.update_is_cond);
  assign train_idx      = bus.update_pc[GHR_BITS+1:2] ^ bus.update_ghr;
  assign train_old      = pht_reg[train_idx];
  assign update_btb_idx = bus.update_pc[BTB_IDX_BITS+1:2];
  assign unused_pc_bits = ^bus.update_pc[1:0];

  always_comb begin
    train_new = train_old;
    if (bus.update_taken) begin
      if (train_old != 2'b11) train_new = train_old + 2'd1;
    end else begin
      if (train_old != 2'b00) train_new = train_old - 2'd1;
    end
  end

  for (genvar gi = 0; gi < PHT_SIZE; gi++) begin : g_pht
    assign pht_next[gi] = (cond_update && train_idx == GHR_BITS'(gi)) ? train_new
                                                                     : pht_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_SIZE; i++) pht_reg[i] <= 2'b01;
      ghr_reg <= '0;
    end else begin
      for (int i = 0; i < PHT_SIZE; i++) pht_reg[i] <= pht_next[i];
      if (cond_update) ghr_reg <= {ghr_reg[GHR_BITS-2:0], bus.update_taken};
    end
  end

  // Only the valid bits need clearing; tag/target/uncond are qualified by valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid_reg <= '0;
    end else if (btb_write) begin
      btb_valid_reg[update_btb_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && btb_write) begin
      btb_tag_reg[update_btb_idx]    <= bus.update_pc[31:BTB_IDX_BITS+2];
      btb_target_reg[update_btb_idx] <= bus.update_target;
      btb_uncond_reg[update_btb_idx] <= !bus.update_is_cond;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_branches_reg    <= '0;
      num_mispredicts_reg <= '0;
    end else if (bus.update_valid) begin
      if (bus.update_is_cond && num_branches_reg != 32'hFFFF_FFFF)
        num_branches_reg <= num_branches_reg + 32'd1;
      if (bus.update_mispredict && num_mispredicts_reg != 32'hFFFF_FFFF)
        num_mispredicts_reg <= num_mispredicts_reg + 32'd1;
    end
  end
endmodule

// File: tb/tb_gshare_resolve_predictor.sv
// Directed bench for gshare_resolve_predictor: an array-based reference model
// checked every cycle, plus literal expectations taken from hand traces.
module tb_gshare_resolve_predictor;
  logic clk;
  logic reset;

  gshare_resolve_predictor_if #(.GHR_BITS(5)) bus ();

  gshare_resolve_predictor #(.GHR_BITS(5), .BTB_IDX_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 32-entry PHT/BTB kept as plain integers.
  int          m_pht   [32];
  bit          m_valid [32];
  int unsigned m_tag   [32];
  int unsigned m_tgt   [32];
  bit          m_unc   [32];
  int unsigned m_ghr;
  longint      m_nb;
  longint      m_nm;
  bit          model_ready = 1'b0;

  function automatic int btb_slot(input logic [31:0] pc);
    return int'((pc >> 2) % 32);
  endfunction

  function automatic int pht_slot(input logic [31:0] pc, input int unsigned g);
    return int'(((pc >> 2) % 32) ^ g);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_pht[i]   <= 1;
        m_valid[i] <= 1'b0;
      end
      m_ghr       <= 0;
      m_nb        <= 0;
      m_nm        <= 0;
      model_ready <= 1'b1;
    end else if (bus.update_valid) begin
      if (bus.update_is_cond) begin
        if (bus.update_taken)
          m_pht[pht_slot(bus.update_pc, bus.update_ghr)] <=
            (m_pht[pht_slot(bus.update_pc, bus.update_ghr)] >= 3) ? 3
              : m_pht[pht_slot(bus.update_pc, bus.update_ghr)] + 1;
        else
          m_pht[pht_slot(bus.update_pc, bus.update_ghr)] <=
            (m_pht[pht_slot(bus.update_pc, bus.update_ghr)] <= 0) ? 0
              : m_pht[pht_slot(bus.update_pc, bus.update_ghr)] - 1;
        m_ghr <= (m_ghr * 2 + (bus.update_taken ? 1 : 0)) % 32;
        if (m_nb < 64'hFFFF_FFFF) m_nb <= m_nb + 1;
      end
      if (bus.update_taken || !bus.update_is_cond) begin
        m_valid[btb_slot(bus.update_pc)] <= 1'b1;
        m_tag[btb_slot(bus.update_pc)]   <= bus.update_pc >> 7;
        m_tgt[btb_slot(bus.update_pc)]   <= bus.update_target;
        m_unc[btb_slot(bus.update_pc)]   <= !bus.update_is_cond;
      end
      if (bus.update_mispredict && m_nm < 64'hFFFF_FFFF) m_nm <= m_nm + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      logic [31:0] pc;
      logic [31:0] exp_pc;
      bit          hit;
      bit          take;
      pc     = bus.IF_pc;
      hit    = m_valid[btb_slot(pc)] && (m_tag[btb_slot(pc)] == (pc >> 7));
      take   = hit && (m_unc[btb_slot(pc)] || m_pht[pht_slot(pc, m_ghr)] >= 2);
      exp_pc = take ? m_tgt[btb_slot(pc)] : pc + 32'd4;
      checks++;
      if (bus.predicted_pc !== exp_pc || bus.pred_taken !== take
          || bus.pred_ghr !== 5'(m_ghr) || bus.num_branches !== 32'(m_nb)
          || bus.num_mispredicts !== 32'(m_nm)) begin
        errors++;
        $display("FAIL model t=%0t IF_pc=%h: got pc=%h tk=%0b ghr=%h nb=%0d nm=%0d, want pc=%h tk=%0b ghr=%h nb=%0d nm=%0d",
                 $time, pc, bus.predicted_pc, bus.pred_taken, bus.pred_ghr,
                 bus.num_branches, bus.num_mispredicts, exp_pc, take, 5'(m_ghr),
                 32'(m_nb), 32'(m_nm));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.update_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_update(input logic [31:0] pc, input logic is_cond, input logic taken,
                            input logic [31:0] target, input logic [4:0] g,
                            input logic mispredict);
    bus.update_valid      = 1'b1;
    bus.update_pc         = pc;
    bus.update_is_cond    = is_cond;
    bus.update_taken      = taken;
    bus.update_target     = target;
    bus.update_ghr        = g;
    bus.update_mispredict = mispredict;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic is_cond, input logic taken,
                           input logic [31:0] target, input logic [4:0] g,
                           input logic mispredict);
    set_update(pc, is_cond, taken, target, g, mispredict);
    @(posedge clk);
    #1;
    bus.update_valid = 1'b0;
    $display("update pc=%h cond=%0b taken=%0b tgt=%h ghr=%h mis=%0b", pc, is_cond,
             taken, target, g, mispredict);
  endtask

  task automatic lookup(input logic [31:0] pc);
    bus.IF_pc = pc;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.IF_pc = 32'h0;
    set_update(32'h0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b0);
    bus.update_valid = 1'b0;

    // Reset state
    do_reset();
    lookup(32'h100);
    chk("reset_pc",    bus.predicted_pc, 32'h104);
    chk("reset_taken", 32'(bus.pred_taken), 32'h0);
    chk("reset_ghr",   32'(bus.pred_ghr), 32'h0);
    chk("reset_nb",    bus.num_branches, 32'h0);
    chk("reset_nm",    bus.num_mispredicts, 32'h0);

    // History training: PHT[8] trained, lookup now indexes PHT[9]
    do_update(32'h20, 1'b1, 1'b1, 32'h40, 5'h0, 1'b0);
    lookup(32'h20);
    chk("hist_ghr",   32'(bus.pred_ghr), 32'h1);
    chk("hist_nb",    bus.num_branches, 32'h1);
    chk("hist_pc",    bus.predicted_pc, 32'h24);
    chk("hist_taken", 32'(bus.pred_taken), 32'h0);

    // jal: BTB only, history and branch count untouched
    do_reset();
    do_update(32'h80, 1'b0, 1'b0, 32'h10, 5'h0, 1'b0);
    lookup(32'h80);
    chk("jal_ghr",   32'(bus.pred_ghr), 32'h0);
    chk("jal_nb",    bus.num_branches, 32'h0);
    chk("jal_pc",    bus.predicted_pc, 32'h10);
    chk("jal_taken", 32'(bus.pred_taken), 32'h1);

    // Saturation: 4 taken then 1 not-taken leaves PHT[8] at 2'b10
    do_reset();
    for (int i = 0; i < 4; i++) do_update(32'h20, 1'b1, 1'b1, 32'h40, 5'h0, 1'b0);
    do_update(32'h20, 1'b1, 1'b0, 32'h40, 5'h0, 1'b0);
    lookup(32'h20);
    chk("sat_ghr", 32'(bus.pred_ghr), 32'h1e);
    for (int i = 0; i < 5; i++) do_update(32'h40, 1'b1, 1'b0, 32'h0, 5'h0, 1'b0);
    lookup(32'h20);
    chk("sat_ghr0",  32'(bus.pred_ghr), 32'h0);
    chk("sat_nb",    bus.num_branches, 32'd10);
    chk("sat_pc",    bus.predicted_pc, 32'h40);
    chk("sat_taken", 32'(bus.pred_taken), 32'h1);

    // Alias at BTB index 8 with a different tag
    do_update(32'hA0, 1'b1, 1'b1, 32'h200, 5'h0, 1'b0);
    lookup(32'h20);
    chk("alias_miss_pc", bus.predicted_pc, 32'h24);
    for (int i = 0; i < 5; i++) do_update(32'h40, 1'b1, 1'b0, 32'h0, 5'h0, 1'b0);
    lookup(32'hA0);
    chk("alias_hit_pc",    bus.predicted_pc, 32'h200);
    chk("alias_hit_taken", 32'(bus.pred_taken), 32'h1);

    // Same-cycle update and lookup: no bypass, visible next cycle
    do_reset();
    bus.IF_pc = 32'h20;
    set_update(32'h20, 1'b0, 1'b0, 32'h40, 5'h0, 1'b0);
    #1;
    chk("same_cycle_pc", bus.predicted_pc, 32'h24);
    @(posedge clk);
    #1;
    bus.update_valid = 1'b0;
    #1;
    chk("next_cycle_pc", bus.predicted_pc, 32'h40);
    bus.IF_pc = 32'h60;
    set_update(32'h60, 1'b1, 1'b1, 32'h400, 5'h0, 1'b0);
    #1;
    chk("same_cycle_cond_pc", bus.predicted_pc, 32'h64);
    @(posedge clk);
    #1;
    bus.update_valid = 1'b0;
    @(posedge clk);
    #1;

    // Update asserted together with reset is discarded
    reset = 1'b1;
    set_update(32'h80, 1'b1, 1'b1, 32'h10, 5'h0, 1'b1);
    @(posedge clk);
    #1;
    bus.update_valid = 1'b0;
    reset = 1'b0;
    lookup(32'h80);
    chk("rst_upd_pc", bus.predicted_pc, 32'h84);
    chk("rst_upd_nb", bus.num_branches, 32'h0);
    chk("rst_upd_nm", bus.num_mispredicts, 32'h0);

    // Mispredict counting, then idle cycles with garbage inputs
    for (int i = 0; i < 3; i++) do_update(32'h100, 1'b0, 1'b0, 32'h300, 5'h0, 1'b1);
    set_update(32'h100, 1'b1, 1'b1, 32'hDEAD_BEEC, 5'h1f, 1'b1);
    bus.update_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lookup(32'h100);
    chk("mis_nm",  bus.num_mispredicts, 32'd3);
    chk("mis_nb",  bus.num_branches, 32'd0);
    chk("mis_pc",  bus.predicted_pc, 32'h300);
    chk("mis_ghr", 32'(bus.pred_ghr), 32'h0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
